ssd_scan_ctl: RTL

Time-multiplexes four 4-bit display codes onto the single shared seven-segment decoder and the active-low digit-select lines of the 4-digit display. New display values are held in a pending register and committed only at a frame boundary, so a frame never shows a mix of old and new digits. Dead time between digits suppresses ghosting. It sits between the keyboard/calculator datapath (code source) and the segment decoder (code sink).

---
 rtl/ssd_pkg.sv | 29 ++
 rtl/ssd_slot_timer.sv | 35 +++
 rtl/ssd_scan_ctl.sv | 88 ++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared codes, select patterns and scan state for the 4-digit seven-segment scanner.
package ssd_pkg;

  localparam logic [3:0] SS_BLANK_CODE = 4'hF;
  localparam logic [3:0] SEL_OFF       = 4'b1111;
  localparam logic [3:0] KEY_ADD       = 4'd10;
  localparam logic [3:0] KEY_SUB       = 4'd11;
  localparam logic [3:0] KEY_MUL       = 4'd12;

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

  function automatic logic [3:0] digit_of(input logic [15:0] v, input logic [1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

  // True when digit i and every digit above it are zero; digit0 is never blanked.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd1:    return (v[15:4] == 12'h000);
      2'd2:    return (v[15:8] == 8'h00);
      2'd3:    return (v[15:12] == 4'h0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot counter and digit index for the display scan; exposes next-cycle values so the
// top can register its outputs in step with the slot they belong to.
module ssd_slot_timer #(
  parameter int REFRESH_DIV = 100000,
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] o_cnt_nxt,
  output logic [1:0]    o_idx_nxt,
  output logic          o_frame_end
);

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          w_slot_end;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign o_frame_end = w_slot_end && (r_idx == 2'd3);
  assign o_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
  assign o_idx_nxt   = w_slot_end ? r_idx + 2'd1 : r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= o_cnt_nxt;
      r_idx <= o_idx_nxt;
    end
  end

endmodule

// File: rtl/ssd_scan_ctl.sv
// Four-digit display scanner: frame-aligned commit of pending codes, dead time per slot.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit0 always shown).
module ssd_scan_ctl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] disp_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  ssd_in,
  output logic [3:0]  ssd_sel
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC);

  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic          w_frame_end;
  scan_state_t   w_state_nxt;
  logic [15:0]   w_shadow_nxt;
  logic [3:0]    w_raw;
  logic [3:0]    w_code;
  logic          w_commit;

  logic [15:0]   r_shadow;
  logic [15:0]   r_pending;
  logic          r_pend_vld;
  logic          r_load_ack;
  logic [3:0]    r_ssd_in;
  logic [3:0]    r_ssd_sel;

  ssd_slot_timer #(.REFRESH_DIV(REFRESH_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .o_cnt_nxt  (w_cnt_nxt),
    .o_idx_nxt  (w_idx_nxt),
    .o_frame_end(w_frame_end)
  );

  assign w_state_nxt = (w_cnt_nxt < DEAD_LAST) ? DEAD : SHOW;

  // A load landing on the boundary itself bypasses the pending register.
  assign w_commit     = w_frame_end && (load || r_pend_vld);
  assign w_shadow_nxt = (w_frame_end && load)       ? disp_in   :
                        (w_frame_end && r_pend_vld) ? r_pending : r_shadow;

  assign w_raw = digit_of(w_shadow_nxt, w_idx_nxt);
`ifdef LEADING_ZERO_BLANK_EN
  assign w_code = ((w_state_nxt == SHOW) && lz_blank(w_shadow_nxt, w_idx_nxt)) ?
                  SS_BLANK_CODE : w_raw;
`else
  assign w_code = w_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow   <= 16'hFFFF;
      r_pending  <= 16'h0000;
      r_pend_vld <= 1'b0;
      r_load_ack <= 1'b0;
      r_ssd_in   <= SS_BLANK_CODE;
      r_ssd_sel  <= SEL_OFF;
    end else begin
      r_shadow   <= w_shadow_nxt;
      r_load_ack <= w_commit;
      if (load && !w_frame_end) begin
        r_pending <= disp_in;
      end
      if (w_frame_end) begin
        r_pend_vld <= 1'b0;
      end else if (load) begin
        r_pend_vld <= 1'b1;
      end
      r_ssd_in  <= w_code;
      r_ssd_sel <= (w_state_nxt == SHOW) ? ~(4'b0001 << w_idx_nxt) : SEL_OFF;
    end
  end

  assign load_ack = r_load_ack;
  assign ssd_in   = r_ssd_in;
  assign ssd_sel  = r_ssd_sel;

endmodule
